cassette_streamer: RTL

Parametrised next-generation CoCo tape playback engine. Streams a cassette image byte-by-byte from SDRAM and serialises each byte LSB-first as a 1200/2400 Hz FSK square wave for the PIA cassette input. The fetch uses a request/acknowledge SDRAM handshake rather than fixed-latency reads. Playback honours the PIA motor line, inserts a silent gap after the namefile block, and stops at the image length or after the EOF block.

---
 rtl/cassette_streamer_if.sv | 23 ++
 rtl/cassette_streamer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cassette_streamer_if.sv
// SDRAM read handshake between cassette_streamer (master) and the memory side (slave).
interface cassette_streamer_if #(
  parameter int ADDR_W = 25
);
  logic [ADDR_W-1:0] sdram_addr;
  logic              sdram_rd;
  logic              sdram_ack;
  logic [7:0]        sdram_data;

  modport master (
    output sdram_addr,
    output sdram_rd,
    input  sdram_ack,
    input  sdram_data
  );

  modport slave (
    input  sdram_addr,
    input  sdram_rd,
    output sdram_ack,
    output sdram_data
  );
endinterface

// File: rtl/cassette_streamer.sv
// CoCo tape playback: streams an SDRAM cassette image as LSB-first 1200/2400 Hz FSK.
// Optional feature macro CASSETTE_NAME_GAP_EN: silent gap after the namefile block.
module cassette_streamer #(
  parameter int ADDR_W    = 25,
  parameter int HALF0     = 372,
  parameter int HALF1     = 186,
  parameter int GAP_TICKS = 445000,
  parameter int HCNT_W    = 19
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                Q,
  input  logic                play,
  input  logic                motor,
  input  logic                rewind,
  input  logic [ADDR_W-1:0]   tape_len,
  cassette_streamer_if.master mem,
  output logic                data,
  output logic [2:0]          status,
  output logic                busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // PH_WAIT: byte latched, first high half starts on the next tick
  typedef enum logic [1:0] {
    PH_WAIT = 2'd0,
    PH_HIGH = 2'd1,
    PH_LOW  = 2'd2
  } phase_t;

  localparam logic [HCNT_W-1:0] H0       = HCNT_W'(HALF0);
  localparam logic [HCNT_W-1:0] H1       = HCNT_W'(HALF1);
  localparam logic [HCNT_W-1:0] GAP_LOAD = HCNT_W'(GAP_TICKS);
  localparam logic [HCNT_W-1:0] CNT_ONE  = HCNT_W'(1);
  localparam logic [HCNT_W-1:0] CNT_ZERO = HCNT_W'(0);
  localparam logic [23:0] SEQ_NAME = 24'h553C00;
  localparam logic [23:0] SEQ_GAP  = 24'h555555;
  localparam logic [23:0] SEQ_EOF  = 24'h553CFF;
  localparam logic [23:0] SEQ_END  = 24'h00FF55;

  state_t            state_r, state_s;
  phase_t            phase_r, phase_s;
  logic              q_prev_r, rewind_prev_r;
  logic [ADDR_W-1:0] addr_r, addr_s, addr_inc_s;
  logic              rd_r, rd_s;
  logic              data_r, data_s;
  logic              eof_r, eof_s;
  logic              busy_r, busy_s;
  logic [23:0]       seq_r, seq_s;
  logic [7:0]        shift_r, shift_s;
  logic [2:0]        bit_idx_r, bit_idx_s;
  logic [HCNT_W-1:0] cnt_r, cnt_s, half_s, half_next_s;
`ifdef CASSETTE_NAME_GAP_EN
  logic              name_r, name_s;
`endif
  logic              tick_s, step_s, rewind_edge_s;

  assign tick_s        = Q & ~q_prev_r;
  assign step_s        = tick_s & play & motor;
  assign rewind_edge_s = rewind & ~rewind_prev_r;
  assign addr_inc_s    = addr_r + ADDR_W'(1);
  assign half_s        = shift_r[bit_idx_r] ? H1 : H0;
  assign half_next_s   = shift_r[bit_idx_r + 3'd1] ? H1 : H0;

  assign mem.sdram_addr = addr_r;
  assign mem.sdram_rd   = rd_r;
  assign data           = data_r;
  assign status         = state_r;
  assign busy           = busy_r;

  // Next-state and datapath decode for the playback FSM
  always_comb begin
    state_s   = state_r;
    phase_s   = phase_r;
    addr_s    = addr_r;
    rd_s      = rd_r;
    data_s    = data_r;
    eof_s     = eof_r;
    seq_s     = seq_r;
    shift_s   = shift_r;
    bit_idx_s = bit_idx_r;
    cnt_s     = cnt_r;
`ifdef CASSETTE_NAME_GAP_EN
    name_s    = name_r;
`endif
    if (rewind_edge_s) begin
      state_s   = ST_IDLE;
      phase_s   = PH_WAIT;
      addr_s    = {ADDR_W{1'b0}};
      rd_s      = 1'b0;
      data_s    = 1'b0;
      eof_s     = 1'b0;
      seq_s     = 24'h000000;
      bit_idx_s = 3'd0;
      cnt_s     = CNT_ZERO;
`ifdef CASSETTE_NAME_GAP_EN
      name_s    = 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          data_s = 1'b0;
          if (step_s) begin
            if (tape_len == {ADDR_W{1'b0}}) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_FETCH;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_FETCH: begin
          data_s = 1'b0;
          // an ack only counts while our request is actually up
          if (rd_r && mem.sdram_ack) begin
            rd_s      = 1'b0;
            shift_s   = mem.sdram_data;
            seq_s     = {seq_r[15:0], mem.sdram_data};
            bit_idx_s = 3'd0;
            phase_s   = PH_WAIT;
            state_s   = ST_SHIFT;
          end else begin
            rd_s = 1'b1;
          end
        end
        ST_SHIFT: begin
          if (step_s) begin
            case (phase_r)
              PH_WAIT: begin
                data_s  = 1'b1;
                cnt_s   = half_s;
                phase_s = PH_HIGH;
              end
              PH_HIGH: begin
                if (cnt_r == CNT_ONE) begin
                  data_s  = 1'b0;
                  cnt_s   = half_s;
                  phase_s = PH_LOW;
                end else begin
                  cnt_s = cnt_r - CNT_ONE;
                end
              end
              PH_LOW: begin
                if (cnt_r != CNT_ONE) begin
                  cnt_s = cnt_r - CNT_ONE;
                end else if (bit_idx_r != 3'd7) begin
                  bit_idx_s = bit_idx_r + 3'd1;
                  data_s    = 1'b1;
                  cnt_s     = half_next_s;
                  phase_s   = PH_HIGH;
                end else begin
                  // byte complete; the counter preload only matters if we enter GAP
                  phase_s = PH_WAIT;
                  addr_s  = addr_inc_s;
                  cnt_s   = GAP_LOAD;
                  if (seq_r == SEQ_EOF) begin
                    eof_s = 1'b1;
                  end else begin
                    eof_s = eof_r;
                  end
`ifdef CASSETTE_NAME_GAP_EN
                  if (seq_r == SEQ_NAME) begin
                    name_s = 1'b1;
                  end else if (seq_r == SEQ_GAP && name_r) begin
                    name_s = 1'b0;
                  end else begin
                    name_s = name_r;
                  end
`endif
                  if (addr_inc_s == tape_len) begin
                    state_s = ST_DONE;
                  end else if (seq_r == SEQ_END && eof_r) begin
                    state_s = ST_DONE;
`ifdef CASSETTE_NAME_GAP_EN
                  end else if (seq_r == SEQ_GAP && name_r) begin
                    state_s = ST_GAP;
`endif
                  end else begin
                    state_s = ST_FETCH;
                  end
                end
              end
              default: phase_s = PH_WAIT;
            endcase
          end else begin
            phase_s = phase_r;
          end
        end
`ifdef CASSETTE_NAME_GAP_EN
        ST_GAP: begin
          data_s = 1'b0;
          if (step_s) begin
            if (cnt_r <= CNT_ONE) begin
              cnt_s   = CNT_ZERO;
              state_s = ST_FETCH;
            end else begin
              cnt_s = cnt_r - CNT_ONE;
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
`endif
        ST_DONE: begin
          data_s  = 1'b0;
          state_s = ST_DONE;
        end
        default: begin
          data_s  = 1'b0;
          state_s = ST_IDLE;
        end
      endcase
    end
    busy_s = (state_s == ST_FETCH) || (state_s == ST_SHIFT) || (state_s == ST_GAP);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath, edge-detect history and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_r       <= PH_WAIT;
      q_prev_r      <= 1'b0;
      rewind_prev_r <= 1'b0;
      addr_r        <= {ADDR_W{1'b0}};
      rd_r          <= 1'b0;
      data_r        <= 1'b0;
      eof_r         <= 1'b0;
      busy_r        <= 1'b0;
      seq_r         <= 24'h000000;
      shift_r       <= 8'h00;
      bit_idx_r     <= 3'd0;
      cnt_r         <= CNT_ZERO;
`ifdef CASSETTE_NAME_GAP_EN
      name_r        <= 1'b0;
`endif
    end else begin
      phase_r       <= phase_s;
      q_prev_r      <= Q;
      rewind_prev_r <= rewind;
      addr_r        <= addr_s;
      rd_r          <= rd_s;
      data_r        <= data_s;
      eof_r         <= eof_s;
      busy_r        <= busy_s;
      seq_r         <= seq_s;
      shift_r       <= shift_s;
      bit_idx_r     <= bit_idx_s;
      cnt_r         <= cnt_s;
`ifdef CASSETTE_NAME_GAP_EN
      name_r        <= name_s;
`endif
    end
  end

endmodule
